dram_arbiter: RTL and testbench

DRAM_ARBITER -- requirements
Module: dram_arbiter

---
 rtl/dram_arbiter.sv | 138 +++++++++++++
 tb/tb_dram_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_arbiter.sv
// dram_arbiter: round-robin arbiter that shares one DRAM port among NUM_CORES
// requesters. Each access is a fixed three-cycle transaction: arbitrate in
// IDLE, drive one memory strobe in ISSUE, acknowledge in CAPTURE.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | port free; choose a round-robin winner and latch its request
// ISSUE   | latched addr/data on the memory bus, one read or write strobe
// CAPTURE | strobes low; read data returned to cores, ack pulse, pointer moves
module dram_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_CORES-1:0]        i_req,
    input  logic [NUM_CORES-1:0]        i_we,
    input  logic [NUM_CORES*ADDR_W-1:0] i_addr,
    input  logic [NUM_CORES*DATA_W-1:0] i_wdata,
    output logic [NUM_CORES-1:0]        o_ack,
    output logic [DATA_W-1:0]           o_rdata,
    output logic [NUM_CORES-1:0]        o_grant,
    output logic [ADDR_W-1:0]           o_mem_addr,
    output logic                        o_mem_read,
    output logic                        o_mem_write,
    output logic [DATA_W-1:0]           o_mem_wdata,
    input  logic [DATA_W-1:0]           i_mem_rdata,
    output logic                        o_busy
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   winner;
    logic               lat_we;
    logic [DATA_W-1:0]  rdata_q;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_CORES-1:0] pick_oh;

    // First requesting core at or after the pointer, wrapping around.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_CORES-1:0] req,
                                                 input logic [IDX_W-1:0]     p);
        int   cand;
        logic found;
        rr_pick = p;
        found   = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            cand = (int'(p) + i) % NUM_CORES;
            if (!found && req[cand]) begin
                found   = 1'b1;
                rr_pick = IDX_W'(cand);
            end
        end
    endfunction

    // Combinational round-robin choice and its one-hot form.
    always_comb begin
        pick_idx          = rr_pick(i_req, ptr);
        pick_oh           = '0;
        pick_oh[pick_idx] = 1'b1;
    end

    // Read data is forwarded straight from DRAM during the ack cycle so it is
    // valid alongside o_ack; the register keeps it afterwards.
    assign o_rdata = (state == S_CAPTURE && !lat_we) ? i_mem_rdata : rdata_q;

    // Transaction sequencer with registered memory-side and core-side outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            ptr         <= '0;
            winner      <= '0;
            lat_we      <= 1'b0;
            rdata_q     <= '0;
            o_ack       <= '0;
            o_grant     <= '0;
            o_mem_addr  <= '0;
            o_mem_read  <= 1'b0;
            o_mem_write <= 1'b0;
            o_mem_wdata <= '0;
            o_busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    o_ack <= '0;
                    if (|i_req) begin
                        winner      <= pick_idx;
                        lat_we      <= i_we[pick_idx];
                        o_grant     <= pick_oh;
                        o_mem_addr  <= i_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        o_mem_wdata <= i_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                        o_mem_write <= i_we[pick_idx];
                        o_mem_read  <= !i_we[pick_idx];
                        o_busy      <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    o_mem_read  <= 1'b0;
                    o_mem_write <= 1'b0;
                    o_ack       <= o_grant;
                    if (int'(winner) == NUM_CORES - 1) begin
                        ptr <= '0;
                    end else begin
                        ptr <= winner + IDX_W'(1);
                    end
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (!lat_we) begin
                        rdata_q <= i_mem_rdata;
                    end
                    o_ack   <= '0;
                    o_grant <= '0;
                    o_busy  <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    o_ack       <= '0;
                    o_grant     <= '0;
                    o_mem_read  <= 1'b0;
                    o_mem_write <= 1'b0;
                    o_busy      <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level reference model of the arbiter.
module tb_dram_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [3:0]  i_req;
    logic [3:0]  i_we;
    logic [63:0] i_addr;
    logic [31:0] i_wdata;
    logic [3:0]  o_ack;
    logic [7:0]  o_rdata;
    logic [3:0]  o_grant;
    logic [15:0] o_mem_addr;
    logic        o_mem_read;
    logic        o_mem_write;
    logic [7:0]  o_mem_wdata;
    logic [7:0]  i_mem_rdata;
    logic        o_busy;

    int errors = 0;
    int checks = 0;

    dram_arbiter #(.NUM_CORES(4), .ADDR_W(16), .DATA_W(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we),
        .i_addr(i_addr), .i_wdata(i_wdata), .o_ack(o_ack), .o_rdata(o_rdata),
        .o_grant(o_grant), .o_mem_addr(o_mem_addr), .o_mem_read(o_mem_read),
        .o_mem_write(o_mem_write), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // DRAM contents as a pure function of address; 0x1234 holds 0xA5.
    function automatic logic [7:0] dram_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h83;
    endfunction

    // DRAM: data appears one cycle after the read strobe, junk otherwise.
    always @(posedge i_clk) begin
        if (o_mem_read) i_mem_rdata <= dram_val(o_mem_addr);
        else            i_mem_rdata <= 8'($urandom);
    end

    // Reference round-robin: first requester starting at p, wrapping mod 4.
    function automatic int rr_ref(input logic [3:0] req, input int p);
        for (int i = 0; i < 4; i++) begin
            if (req[(p + i) % 4]) return (p + i) % 4;
        end
        return p;
    endfunction

    task automatic step;
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_core(input int k, input logic we, input logic [15:0] a, input logic [7:0] d);
        i_we[k] = we;
        i_addr[k*16 +: 16] = a;
        i_wdata[k*8 +: 8] = d;
    endtask

    task automatic do_reset;
        i_rst = 1'b1; i_req = '0; i_we = '0; i_addr = '0; i_wdata = '0;
        step; step;
        i_rst = 1'b0;
    endtask

    task automatic test_reset;
        i_rst = 1'b1; i_req = 4'hF; i_we = 4'h5; i_addr = '1; i_wdata = '1;
        step; step;
        checks++; if (o_ack !== 4'h0)       begin errors++; $display("FAIL reset_ack got=%h exp=0", o_ack); end
        checks++; if (o_grant !== 4'h0)     begin errors++; $display("FAIL reset_grant got=%h exp=0", o_grant); end
        checks++; if (o_mem_read !== 1'b0)  begin errors++; $display("FAIL reset_read got=%b exp=0", o_mem_read); end
        checks++; if (o_mem_write !== 1'b0) begin errors++; $display("FAIL reset_write got=%b exp=0", o_mem_write); end
        checks++; if (o_mem_addr !== 16'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", o_mem_addr); end
        checks++; if (o_mem_wdata !== 8'h0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", o_mem_wdata); end
        checks++; if (o_rdata !== 8'h0)     begin errors++; $display("FAIL reset_rdata got=%h exp=0", o_rdata); end
        checks++; if (o_busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        i_rst = 1'b0; i_req = '0;
        step;
    endtask

    task automatic test_read_core2;
        do_reset;
        set_core(2, 1'b0, 16'h1234, 8'h00);
        i_req = 4'b0100;
        step;
        checks++; if (o_mem_read !== 1'b1)     begin errors++; $display("FAIL rd2_read got=%b exp=1", o_mem_read); end
        checks++; if (o_mem_write !== 1'b0)    begin errors++; $display("FAIL rd2_write got=%b exp=0", o_mem_write); end
        checks++; if (o_mem_addr !== 16'h1234) begin errors++; $display("FAIL rd2_addr got=%h exp=1234", o_mem_addr); end
        checks++; if (o_grant !== 4'b0100)     begin errors++; $display("FAIL rd2_grant got=%b exp=0100", o_grant); end
        checks++; if (o_busy !== 1'b1)         begin errors++; $display("FAIL rd2_busy got=%b exp=1", o_busy); end
        step;
        checks++; if (o_ack !== 4'b0100)       begin errors++; $display("FAIL rd2_ack got=%b exp=0100", o_ack); end
        checks++; if (o_rdata !== 8'hA5)       begin errors++; $display("FAIL rd2_rdata got=%h exp=a5", o_rdata); end
        checks++; if (o_mem_read !== 1'b0)     begin errors++; $display("FAIL rd2_read_low got=%b exp=0", o_mem_read); end
        i_req = '0;
        step;
        checks++; if (o_ack !== 4'b0000)       begin errors++; $display("FAIL rd2_ack_end got=%b exp=0000", o_ack); end
        checks++; if (o_grant !== 4'b0000)     begin errors++; $display("FAIL rd2_grant_end got=%b exp=0000", o_grant); end
        checks++; if (o_rdata !== 8'hA5)       begin errors++; $display("FAIL rd2_rdata_hold got=%h exp=a5", o_rdata); end
    endtask

    task automatic test_write_core1;
        do_reset;
        set_core(1, 1'b1, 16'h00FF, 8'h3C);
        i_req = 4'b0010;
        step;
        checks++; if (o_mem_write !== 1'b1)    begin errors++; $display("FAIL wr1_write got=%b exp=1", o_mem_write); end
        checks++; if (o_mem_read !== 1'b0)     begin errors++; $display("FAIL wr1_read got=%b exp=0", o_mem_read); end
        checks++; if (o_mem_addr !== 16'h00FF) begin errors++; $display("FAIL wr1_addr got=%h exp=00ff", o_mem_addr); end
        checks++; if (o_mem_wdata !== 8'h3C)   begin errors++; $display("FAIL wr1_wdata got=%h exp=3c", o_mem_wdata); end
        step;
        checks++; if (o_mem_write !== 1'b0)    begin errors++; $display("FAIL wr1_write_low got=%b exp=0", o_mem_write); end
        checks++; if (o_ack !== 4'b0010)       begin errors++; $display("FAIL wr1_ack got=%b exp=0010", o_ack); end
        checks++; if (o_rdata !== 8'h00)       begin errors++; $display("FAIL wr1_rdata_hold got=%h exp=00", o_rdata); end
        i_req = '0;
        step;
    endtask

    task automatic test_all_four;
        logic [3:0] e_ack;
        logic       e_busy;
        do_reset;
        for (int k = 0; k < 4; k++) set_core(k, 1'b0, 16'(16'h0400 + k), 8'h00);
        i_req = 4'hF;
        for (int t = 1; t <= 12; t++) begin
            step;
            e_ack  = (t % 3 == 2) ? (4'b0001 << ((t - 2) / 3)) : 4'b0000;
            e_busy = (t % 3 != 0);
            checks++; if (o_ack !== e_ack)   begin errors++; $display("FAIL all4_ack t=%0d got=%b exp=%b", t, o_ack, e_ack); end
            checks++; if (o_busy !== e_busy) begin errors++; $display("FAIL all4_busy t=%0d got=%b exp=%b", t, o_busy, e_busy); end
            i_req = i_req & ~e_ack;
        end
        i_req = '0;
        step;
    endtask

    task automatic test_starvation;
        int   c0;
        logic found;
        do_reset;
        set_core(0, 1'b0, 16'h0100, 8'h00);
        set_core(3, 1'b1, 16'h0300, 8'h77);
        set_core(1, 1'b0, 16'h0101, 8'h00);
        i_req = 4'b0001;
        step;
        checks++; if (o_grant !== 4'b0001) begin errors++; $display("FAIL starve_first got=%b exp=0001", o_grant); end
        i_req[3] = 1'b1;
        c0 = 0; found = 1'b0;
        for (int n = 0; n < 12; n++) begin
            step;
            if (o_ack[0]) c0++;
            if (o_ack[3]) begin found = 1'b1; break; end
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL starve_core3 got=%b exp=1 (ack within budget)", found); end
        checks++; if (c0 > 1)         begin errors++; $display("FAIL starve_count got=%0d exp<=1 core0 acks", c0); end
        i_req[3] = 1'b0;
        i_req[1] = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step;
            if (o_grant != 4'b0000) break;
        end
        checks++; if (o_grant !== 4'b0001) begin errors++; $display("FAIL starve_ptr got=%b exp=0001", o_grant); end
        i_req = '0;
        step; step; step;
    endtask

    task automatic test_reset_mid;
        do_reset;
        set_core(2, 1'b0, 16'h0222, 8'h00);
        i_req = 4'b0100;
        step; step;
        i_req = '0;
        step;
        set_core(1, 1'b0, 16'h1111, 8'h00);
        i_req = 4'b0010;
        step;
        checks++; if (o_grant !== 4'b0010) begin errors++; $display("FAIL rstmid_issue got=%b exp=0010", o_grant); end
        i_rst = 1'b1;
        step;
        checks++; if (o_ack !== 4'b0000)    begin errors++; $display("FAIL rstmid_ack got=%b exp=0000", o_ack); end
        checks++; if (o_mem_read !== 1'b0)  begin errors++; $display("FAIL rstmid_read got=%b exp=0", o_mem_read); end
        checks++; if (o_busy !== 1'b0)      begin errors++; $display("FAIL rstmid_busy got=%b exp=0", o_busy); end
        i_rst = 1'b0;
        set_core(2, 1'b0, 16'h2222, 8'h00);
        set_core(3, 1'b0, 16'h3333, 8'h00);
        i_req = 4'b1100;
        step;
        checks++; if (o_ack !== 4'b0000)   begin errors++; $display("FAIL rstmid_noack got=%b exp=0000", o_ack); end
        checks++; if (o_grant !== 4'b0100) begin errors++; $display("FAIL rstmid_ptr got=%b exp=0100", o_grant); end
        i_req = '0;
        step;
        checks++; if (o_ack !== 4'b0100)   begin errors++; $display("FAIL rstmid_done got=%b exp=0100", o_ack); end
        step;
    endtask

    task automatic test_addr_change;
        do_reset;
        set_core(0, 1'b0, 16'h0BEE, 8'h00);
        i_req = 4'b0001;
        step;
        checks++; if (o_mem_addr !== 16'h0BEE) begin errors++; $display("FAIL latch_addr got=%h exp=0bee", o_mem_addr); end
        set_core(0, 1'b1, 16'h7777, 8'h99);
        step;
        checks++; if (o_ack !== 4'b0001)             begin errors++; $display("FAIL latch_ack got=%b exp=0001", o_ack); end
        checks++; if (o_rdata !== dram_val(16'h0BEE)) begin errors++; $display("FAIL latch_rdata got=%h exp=%h", o_rdata, dram_val(16'h0BEE)); end
        i_req = '0;
        step;
    endtask

    task automatic test_random;
        int          ph, w, ptr;
        logic        arb, m_we;
        logic [15:0] m_addr;
        logic [7:0]  m_wdata, m_rdata;
        logic [3:0]  sreq, swe, e_ack, e_grant;
        logic [63:0] saddr;
        logic [31:0] swd;
        logic        e_rd, e_wr, e_busy;
        int          wait_t[4];
        do_reset;
        ph = 0; ptr = 0; w = 0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
        for (int k = 0; k < 4; k++) wait_t[k] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            sreq = i_req; swe = i_we; saddr = i_addr; swd = i_wdata;
            step;
            e_ack = '0; e_grant = '0; e_rd = 1'b0; e_wr = 1'b0; e_busy = 1'b0; arb = 1'b0;
            if (ph == 0) begin
                if (sreq != 4'b0) begin
                    arb     = 1'b1;
                    w       = rr_ref(sreq, ptr);
                    m_we    = swe[w];
                    m_addr  = saddr[w*16 +: 16];
                    m_wdata = swd[w*8 +: 8];
                    ph      = 1;
                    e_grant = 4'b0001 << w;
                    e_rd    = !m_we;
                    e_wr    = m_we;
                    e_busy  = 1'b1;
                end
            end else if (ph == 1) begin
                ph      = 2;
                e_ack   = 4'b0001 << w;
                e_grant = e_ack;
                e_busy  = 1'b1;
                ptr     = (w + 1) % 4;
                if (!m_we) m_rdata = dram_val(m_addr);
            end else begin
                ph = 0;
            end
            checks++; if (o_ack !== e_ack)       begin errors++; $display("FAIL rand_ack cyc=%0d got=%b exp=%b", cyc, o_ack, e_ack); end
            checks++; if (o_grant !== e_grant)   begin errors++; $display("FAIL rand_grant cyc=%0d got=%b exp=%b", cyc, o_grant, e_grant); end
            checks++; if (o_mem_read !== e_rd)   begin errors++; $display("FAIL rand_read cyc=%0d got=%b exp=%b", cyc, o_mem_read, e_rd); end
            checks++; if (o_mem_write !== e_wr)  begin errors++; $display("FAIL rand_write cyc=%0d got=%b exp=%b", cyc, o_mem_write, e_wr); end
            checks++; if (o_busy !== e_busy)     begin errors++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, o_busy, e_busy); end
            checks++; if (o_rdata !== m_rdata)   begin errors++; $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", cyc, o_rdata, m_rdata); end
            if (e_rd || e_wr) begin
                checks++; if (o_mem_addr !== m_addr) begin errors++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", cyc, o_mem_addr, m_addr); end
                if (e_wr) begin
                    checks++; if (o_mem_wdata !== m_wdata) begin errors++; $display("FAIL rand_wdata cyc=%0d got=%h exp=%h", cyc, o_mem_wdata, m_wdata); end
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (arb && sreq[k]) wait_t[k]++;
                if (e_ack[k]) begin
                    checks++; if (wait_t[k] > 4) begin errors++; $display("FAIL rand_starve core=%0d got=%0d exp<=4 transactions", k, wait_t[k]); end
                    wait_t[k] = 0;
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (e_ack[k]) begin
                    if ($urandom_range(3) == 0) set_core(k, 1'($urandom), 16'($urandom), 8'($urandom));
                    else i_req[k] = 1'b0;
                end else if (!i_req[k]) begin
                    if ($urandom_range(2) == 0) begin
                        set_core(k, 1'($urandom), 16'($urandom), 8'($urandom));
                        i_req[k] = 1'b1;
                    end
                end else if (ph == 1 && w == k && $urandom_range(7) == 0) begin
                    i_req[k] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    i_addr[k*16 +: 16] = 16'($urandom);
                    i_wdata[k*8 +: 8]  = 8'($urandom);
                end
            end
        end
        i_req = '0;
        step; step; step;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; i_req = '0; i_we = '0; i_addr = '0; i_wdata = '0;
        test_reset;
        test_read_core2;
        test_write_core1;
        test_all_four;
        test_starvation;
        test_reset_mid;
        test_addr_change;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
